btn_debounce_multi: RTL

- Parametrised successor to the single-button interface of the function generator.
- Debounces NUM_BTN independent external push-buttons on the Fg_CLK domain.
- Produces a debounced level and one-cycle pulses per channel: press, release and long-press (plus auto-repeat when compiled in).
- Sits between the board button pins and the front-panel control FSM (waveform/frequency/amplitude select).

---
 rtl/btn_debounce_multi.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button debouncer with press/release/long-press pulses.
// Optional auto-repeat pulses are compiled in with `define BTN_AUTOREPEAT_EN.
module btn_debounce_multi #(
  parameter int unsigned NUM_BTN      = 3,
  parameter int unsigned ACTIVE_LOW   = 1,
  parameter int unsigned DEBOUNCE_CYC = 2400,
  parameter int unsigned LONG_CYC     = 12000000,
  parameter int unsigned REPEAT_CYC   = 3000000
) (
  input  logic               Fg_CLK,
  input  logic               Ext_RESETn,
  input  logic [NUM_BTN-1:0] iExtBtn,
  output logic [NUM_BTN-1:0] oLevel,
  output logic [NUM_BTN-1:0] oPress,
  output logic [NUM_BTN-1:0] oRelease,
  output logic [NUM_BTN-1:0] oLong,
  output logic [NUM_BTN-1:0] oRepeat
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned HW = $clog2(LONG_CYC + 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_CYC + 1);
`endif
  localparam logic [NUM_BTN-1:0] IDLE_PINS = {NUM_BTN{ACTIVE_LOW != 0}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_t;

  if (NUM_BTN < 1 || NUM_BTN > 16 || DEBOUNCE_CYC < 1 || LONG_CYC < 2 || REPEAT_CYC < 1)
  begin : g_param_check
    $error("btn_debounce_multi: parameter out of range");
  end

  // Two-flop synchroniser; reset loads the idle pin level so no false press follows reset.
  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;
  logic [NUM_BTN-1:0] w_pressed;

  always_ff @(posedge Fg_CLK or negedge Ext_RESETn) begin
    if (!Ext_RESETn) begin
      r_sync1 <= IDLE_PINS;
      r_sync2 <= IDLE_PINS;
    end else begin
      r_sync1 <= iExtBtn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = r_sync2 ^ IDLE_PINS;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    logic [DW-1:0] r_deb_cnt;
    logic          r_stable;
    logic [HW-1:0] r_hold;
    state_t        r_state;
    logic          r_press;
    logic          r_release;
    logic          r_long;
    logic          w_accept;
    logic          w_accept_press;
    logic          w_accept_rel;
    logic          w_long_hit;

    assign w_accept       = (w_pressed[i] != r_stable) && (r_deb_cnt == DW'(DEBOUNCE_CYC - 1));
    assign w_accept_press = w_accept && !r_stable;
    assign w_accept_rel   = w_accept && r_stable;
    // A release accepted on the very edge the hold would mature wins over the long pulse.
    assign w_long_hit     = (r_state == ST_PRESSED) && (r_hold == HW'(LONG_CYC - 2)) && !w_accept_rel;

    always_ff @(posedge Fg_CLK or negedge Ext_RESETn) begin
      if (!Ext_RESETn) begin
        r_deb_cnt <= '0;
        r_stable  <= 1'b0;
      end else if (w_pressed[i] == r_stable) begin
        r_deb_cnt <= '0;
      end else if (w_accept) begin
        r_stable  <= w_pressed[i];
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + DW'(1);
      end
    end

    always_ff @(posedge Fg_CLK or negedge Ext_RESETn) begin
      if (!Ext_RESETn) begin
        r_hold <= '0;
      end else if (!r_stable) begin
        r_hold <= '0;
      end else if (r_hold != HW'(LONG_CYC)) begin
        r_hold <= r_hold + HW'(1);
      end
    end

    // Channel FSM with its registered event pulses.
    always_ff @(posedge Fg_CLK or negedge Ext_RESETn) begin
      if (!Ext_RESETn) begin
        r_state   <= ST_IDLE;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
      end else begin
        r_press   <= w_accept_press;
        r_release <= w_accept_rel;
        r_long    <= w_long_hit;
        case (r_state)
          ST_IDLE: begin
            if (w_accept_press) r_state <= ST_PRESSED;
          end
          ST_PRESSED: begin
            if (w_accept_rel)    r_state <= ST_IDLE;
            else if (w_long_hit) r_state <= ST_LONG;
          end
          ST_LONG: begin
            if (w_accept_rel) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end

    assign oLevel[i]   = r_stable;
    assign oPress[i]   = r_press;
    assign oRelease[i] = r_release;
    assign oLong[i]    = r_long;

`ifdef BTN_AUTOREPEAT_EN
    logic [RW-1:0] r_rep_cnt;
    logic          r_repeat;

    // Repeat period starts at the long pulse; the release edge suppresses any pending pulse.
    always_ff @(posedge Fg_CLK or negedge Ext_RESETn) begin
      if (!Ext_RESETn) begin
        r_rep_cnt <= '0;
        r_repeat  <= 1'b0;
      end else begin
        r_repeat <= 1'b0;
        if ((r_state != ST_LONG) || w_accept_rel) begin
          r_rep_cnt <= '0;
        end else if (r_rep_cnt == RW'(REPEAT_CYC - 1)) begin
          r_rep_cnt <= '0;
          r_repeat  <= 1'b1;
        end else begin
          r_rep_cnt <= r_rep_cnt + RW'(1);
        end
      end
    end

    assign oRepeat[i] = r_repeat;
`else
    assign oRepeat[i] = 1'b0;
`endif
  end

endmodule
